g_adder_arbiter32: RTL

Arbitrated sequencer that shares one 32-bit gate-level full adder (G_FullAdder32) between two independent requesters. It accepts add requests over valid/ready handshakes and grants them round-robin. It drives the adder's In1/In2/CI/Enable from registers, captures Out/CO one cycle later, and returns the result on the granting port's response channel. It sits between ALU-level clients and the single shared adder instance.

---
 rtl/g_adder_arbiter32_if.sv | 23 ++
 rtl/g_adder_arbiter32.sv | 104 ++++++++++
 2 files changed

// File: rtl/g_adder_arbiter32_if.sv
// One requester's channel into the shared-adder arbiter: the request handshake
// with its operands, and the response handshake with the registered result.
interface g_adder_arbiter32_if #(parameter int WIDTH = 32);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_ci;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_co;

   modport master (
      output req_valid, req_a, req_b, req_ci, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_co
   );

   modport slave (
      input  req_valid, req_a, req_b, req_ci, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_co
   );
endinterface

// File: rtl/g_adder_arbiter32.sv
// Round-robin sequencer sharing one combinational 32-bit adder between two
// requesters: accept, drive the adder for one cycle, then hold the result.
module g_adder_arbiter32 #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   g_adder_arbiter32_if.slave   p0,
   g_adder_arbiter32_if.slave   p1,
   output logic [WIDTH-1:0]     add_in1,
   output logic [WIDTH-1:0]     add_in2,
   output logic                 add_ci,
   output logic                 add_enable,
   input  logic [WIDTH-1:0]     add_out,
   input  logic                 add_co,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state, state_next;
   logic             last_grant;
   logic             grant;
   logic             sel;
   logic             accept;
   logic [1:0]       req_valid;
   logic [1:0]       rsp_ready;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_co;
   logic [WIDTH-1:0] rsp_sum [2];

   assign req_valid = {p1.req_valid, p0.req_valid};
   assign rsp_ready = {p1.rsp_ready, p0.rsp_ready};

   // A tie goes to the port that did not win last time.
   assign sel    = (&req_valid) ? ~last_grant : req_valid[1];
   assign accept = rst_n && (state == IDLE) && (|req_valid);

   assign p0.req_ready = accept && !sel;
   assign p1.req_ready = accept && sel;
   assign p0.rsp_valid = rsp_valid[0];
   assign p1.rsp_valid = rsp_valid[1];
   assign p0.rsp_sum   = rsp_sum[0];
   assign p1.rsp_sum   = rsp_sum[1];
   assign p0.rsp_co    = rsp_co[0];
   assign p1.rsp_co    = rsp_co[1];
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      // NOTE: state registers use <= so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: default first, so no path through the case leaves it unassigned (no latch).
      state_next = state;
      unique case (state)
         IDLE:    if (|req_valid) state_next = ISSUE;
         ISSUE:   state_next = RESP;
         RESP:    if (rsp_ready[grant]) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         grant      <= 1'b0;
         add_in1    <= '0;
         add_in2    <= '0;
         add_ci     <= 1'b0;
         add_enable <= 1'b0;
         rsp_valid  <= '0;
         rsp_co     <= '0;
         rsp_sum[0] <= '0;
         rsp_sum[1] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  add_in1    <= sel ? p1.req_a  : p0.req_a;
                  add_in2    <= sel ? p1.req_b  : p0.req_b;
                  add_ci     <= sel ? p1.req_ci : p0.req_ci;
                  add_enable <= 1'b1;
                  grant      <= sel;
               end
            end
            ISSUE: begin
               rsp_sum[grant]   <= add_out;
               rsp_co[grant]    <= add_co;
               rsp_valid[grant] <= 1'b1;
               add_enable       <= 1'b0;
               last_grant       <= grant;
            end
            RESP: begin
               if (rsp_ready[grant]) rsp_valid[grant] <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
